// File: rtl/divider_seq_if.sv
// Start/busy/done handshake bundle for the sequential divider.
// The controller side drives operands and start; the divider side returns results and status.
interface divider_seq_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/divider_seq.sv
// Sequential restoring divider: one quotient bit per clock, MSB first.
// Unsigned WIDTH-bit operands; a zero divisor short-circuits to a one-cycle flagged result.
module divider_seq #(
  parameter int WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  divider_seq_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] prem_q, prem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic        [WIDTH:0]   prem_sh;
  logic signed [WIDTH+1:0] diff;
  logic                    qbit;
  logic        [WIDTH-1:0] rem_next;
  logic        [WIDTH-1:0] quo_next;

  // Trial subtraction of the divisor from the shifted partial remainder, one guard bit for sign.
  function automatic logic signed [WIDTH+1:0] trial_sub(
    input logic [WIDTH:0]   sh,
    input logic [WIDTH-1:0] d
  );
    return $signed({1'b0, sh}) - $signed({2'b00, d});
  endfunction

  always_comb begin
    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    prem_d      = prem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;

    // The shifted value needs WIDTH+1 bits; after the subtract/restore it is always below
    // the divisor again, so the stored partial remainder fits in WIDTH bits.
    prem_sh  = {prem_q, dvd_q[WIDTH-1]};
    diff     = trial_sub(prem_sh, dvs_q);
    qbit     = (diff >= 0);
    rem_next = qbit ? diff[WIDTH-1:0] : prem_sh[WIDTH-1:0];
    // Quotient bits enter the dividend register from the bottom as dividend bits leave the top.
    quo_next = {dvd_q[WIDTH-2:0], qbit};

    unique case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.start) begin
          if (bus.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            state_d = RUN;
            dvd_d   = bus.dividend;
            dvs_d   = bus.divisor;
            prem_d  = '0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        dvd_d  = quo_next;
        prem_d = rem_next;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          state_d     = DONE;
          quotient_d  = quo_next;
          remainder_d = rem_next;
          dbz_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      prem_q      <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      prem_q      <= prem_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q == RUN);
  assign bus.done        = (state_q == DONE);

endmodule

// File: doc/divider_seq.md
# divider_seq

Sequential restoring divider: the inverse operation of the combinational carry-save array multiplier. It takes an unsigned WIDTH-bit dividend and divisor, computes one quotient bit per clock, and returns the quotient and remainder. A start/busy/done handshake lets a controller issue divisions back-to-back. It sits beside the multiplier in the arithmetic library, and the two are cross-checked through the identity quotient*divisor + remainder == dividend.

## Interface
- WIDTH, 4, operand, quotient and remainder width in bits (WIDTH >= 2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  request; sampled only in IDLE or DONE
- dividend  in  WIDTH  unsigned dividend; sampled on the accepting edge only
- divisor  in  WIDTH  unsigned divisor; sampled on the accepting edge only
- quotient  out  WIDTH  registered quotient
- remainder  out  WIDTH  registered remainder
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse, high while in DONE
- div_by_zero  out  1  registered flag for the last result; valid from done onward

## Operation
- States: IDLE, RUN, DONE.
- Reset (rst_n low, asynchronous):
  - state = IDLE.
  - quotient, remainder, busy, done, div_by_zero = 0.
  - Internal registers and iteration counter = 0.
- IDLE:
  - start=1 with divisor != 0: latch operands, clear the partial remainder and the counter, go to RUN.
  - start=1 with divisor == 0: go directly to DONE with quotient = all ones, remainder = dividend, div_by_zero = 1.
  - start=0: stay in IDLE.
- RUN, one iteration per cycle, MSB first, for exactly WIDTH cycles:
  - Shift the partial remainder left, bringing in the next dividend bit. The partial remainder is WIDTH+1 bits wide so the shift never overflows.
  - Trial-subtract the divisor. If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After iteration WIDTH-1, load quotient and remainder, clear div_by_zero, go to DONE.
- DONE:
  - Lasts exactly one cycle, then returns to IDLE.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back operation).
- start in RUN is ignored; latched operands are unaffected.
- quotient, remainder and div_by_zero hold their last values until the next result loads. They do not change during RUN.
- dividend and divisor may change freely after the accepting edge.
- Results always satisfy quotient*divisor + remainder == dividend, with remainder < divisor, whenever divisor != 0.

## Timing
- Accepting edge = edge E where start=1 and state is IDLE or DONE.
- Nonzero divisor:
  - busy is high for cycles E+1 through E+WIDTH.
  - done is high in cycle E+WIDTH+1; results are valid from that cycle.
  - Latency is WIDTH+1 cycles (5 cycles for WIDTH=4).
- Zero divisor: done is high in cycle E+1 and busy is never asserted (latency 1 cycle).
- Back-to-back: start held high continuously gives one result per WIDTH+1 cycles.
- busy and done are never high together.
- rst_n low mid-RUN aborts immediately. The partial result is discarded, all outputs return to 0, and no done pulse is issued for the aborted request.
- Release of rst_n is synchronised by the integrator; the block assumes a clean deassertion.

## Test plan
- Reset, then start with dividend=12, divisor=2 -> after 5 cycles done pulses once with quotient=6, remainder=0, div_by_zero=0; busy is high for exactly 4 cycles.
- Directed set 13/4, 3/7, 15/1, 15/15 -> results 3 r1, 0 r3, 15 r0, 1 r0, each with the correct done timing.
- dividend=9, divisor=0 -> done in the next cycle, quotient=15, remainder=9, div_by_zero=1, busy never high. A following 8/3 then clears div_by_zero and gives 2 r2.
- start pulsed again in the 2nd RUN cycle with different operands -> ignored; the original result is returned and only one done pulse occurs.
- rst_n driven low in the 3rd RUN cycle, then released and 10/3 started -> all outputs are 0 during reset, there is no done for the aborted op, and the new op yields 3 r1.
- Exhaustive run with start held high over all 256 operand pairs -> one done every 5 cycles (1 cycle for zero divisor). Every nonzero-divisor result satisfies quotient*divisor + remainder == dividend, with the product checked against the multiplier.
